// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
//   Sequences divide/remu ops for the iterative divider in Execute. Ops from
//   the reservation station are queued in a small FIFO. They are issued one at a time
//   with operands held steady until the divider result is consumed. Divide-by-zero
//   and signed overflow are resolved locally without using the divider.
//   Results are presented to the CDB until granted. A flush empties the queue and
//   drains any divide still in flight.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   flush             mispredict flush (synchronous)
//   enq_*             request queue push interface (valid/ready)
//   div_valid_in      start pulse to divider; div_ready = divider idle
//   div_rob/op/...    operands to divider, held while the op is outstanding
//   div_valid_out     divider result valid; div_yumi = result consumed
//   div_result(_rob)  divider result and its ROB tag
//   cdb_req/grant     CDB request / same-cycle grant
//   cdb_rob/result    result presented on the CDB
module div_issue_ctrl #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        enq_valid,
  output logic        enq_ready,
  input  logic [3:0]  enq_rob,
  input  logic        enq_op,
  input  logic [31:0] enq_dividend,
  input  logic [31:0] enq_divisor,
  output logic        div_valid_in,
  input  logic        div_ready,
  output logic [3:0]  div_rob,
  output logic        div_op,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_valid_out,
  output logic        div_yumi,
  input  logic [31:0] div_result,
  input  logic [3:0]  div_result_rob,
  output logic        cdb_req,
  input  logic        cdb_grant,
  output logic [3:0]  cdb_rob,
  output logic [31:0] cdb_result
);

  typedef enum logic [2:0] {IDLE, LOAD, BUSY, RESULT, DRAIN} state_t;

  typedef struct packed {
    logic [3:0]  rob;
    logic        op;
    logic [31:0] dividend;
    logic [31:0] divisor;
  } entry_t;

  state_t state_reg, state_next;

  entry_t             queue_mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]     count_reg;
  logic               full, empty, push, pop;

  logic [3:0]         inflight_rob_reg;
  logic               inflight_op_reg;
  logic [31:0]        inflight_dividend_reg, inflight_divisor_reg;

  logic [31:0]        result_reg, result_next;
  logic [3:0]         result_rob_reg, result_rob_next;

  logic               div_by_zero, signed_ovf, special;
  logic [31:0]        special_value;
  logic               operands_live;

  // ---------------- request queue ----------------
  assign full      = (count_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign enq_ready = !full;
  // A flush discards anything offered in the same cycle.
  assign push      = enq_valid && enq_ready && !flush;

  // Storage has no reset so it maps onto plain RAM; validity comes from count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      queue_mem[wr_ptr_reg] <= '{rob: enq_rob, op: enq_op,
                                 dividend: enq_dividend, divisor: enq_divisor};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // ---------------- in-flight op and result registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight_rob_reg      <= '0;
      inflight_op_reg       <= 1'b0;
      inflight_dividend_reg <= '0;
      inflight_divisor_reg  <= '0;
      result_reg            <= '0;
      result_rob_reg        <= '0;
      state_reg             <= IDLE;
    end else begin
      if (pop) begin
        inflight_rob_reg      <= queue_mem[rd_ptr_reg].rob;
        inflight_op_reg       <= queue_mem[rd_ptr_reg].op;
        inflight_dividend_reg <= queue_mem[rd_ptr_reg].dividend;
        inflight_divisor_reg  <= queue_mem[rd_ptr_reg].divisor;
      end
      result_reg     <= result_next;
      result_rob_reg <= result_rob_next;
      state_reg      <= state_next;
    end
  end

  // ---------------- special cases ----------------
  assign div_by_zero = (inflight_divisor_reg == 32'h0);
  assign signed_ovf  = inflight_op_reg && (inflight_dividend_reg == 32'h8000_0000) &&
                       (inflight_divisor_reg == 32'hFFFF_FFFF);
  assign special     = div_by_zero || signed_ovf;
  always_comb begin
    special_value = 32'h8000_0000;
    if (div_by_zero) special_value = inflight_op_reg ? 32'hFFFF_FFFF : inflight_dividend_reg;
  end

  // ---------------- FSM next state / outputs ----------------
  always_comb begin
    state_next      = state_reg;
    result_next     = result_reg;
    result_rob_next = result_rob_reg;
    pop             = 1'b0;
    div_valid_in    = 1'b0;
    div_yumi        = 1'b0;
    cdb_req         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (special) begin
          result_next     = special_value;
          result_rob_next = inflight_rob_reg;
          state_next      = RESULT;
        end else begin
          div_valid_in = div_ready;
          if (div_ready) state_next = BUSY;
        end
      end
      BUSY: begin
        div_yumi = div_valid_out;
        if (div_valid_out) begin
          result_next     = div_result;
          result_rob_next = inflight_rob_reg;
          state_next      = RESULT;
        end
      end
      RESULT: begin
        cdb_req = 1'b1;
        if (cdb_grant) state_next = IDLE;
      end
      DRAIN: begin
        div_yumi = div_valid_out;
        if (div_valid_out) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (flush) begin
      pop             = 1'b0;
      div_valid_in    = 1'b0;
      result_next     = result_reg;
      result_rob_next = result_rob_reg;
      if (state_reg == BUSY) begin
        // Leave a result arriving in the flush cycle unconsumed so DRAIN sees it
        // and always has exactly one divider result to discard.
        div_yumi   = 1'b0;
        state_next = DRAIN;
      end else if (state_reg != DRAIN) begin
        state_next = IDLE;
      end
    end
  end

  // Operands stay on the divider bus until its result has been consumed.
  assign operands_live = (state_reg == LOAD) || (state_reg == BUSY) || (state_reg == DRAIN);
  assign div_rob       = operands_live ? inflight_rob_reg      : '0;
  assign div_op        = operands_live ? inflight_op_reg       : 1'b0;
  assign div_dividend  = operands_live ? inflight_dividend_reg : '0;
  assign div_divisor   = operands_live ? inflight_divisor_reg  : '0;

  assign cdb_rob       = (state_reg == RESULT) ? result_rob_reg : '0;
  assign cdb_result    = (state_reg == RESULT) ? result_reg     : '0;

  // The divider must return the tag of the op it was given.
  a_result_tag: assert property (@(posedge clk) disable iff (reset)
    (((state_reg == BUSY) || (state_reg == DRAIN)) && div_valid_out)
      |-> (div_result_rob == inflight_rob_reg));

endmodule

// File: tb/tb_div_issue_ctrl.sv
module tb_div_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        enq_valid = 1'b0;
  logic        enq_ready;
  logic [3:0]  enq_rob = '0;
  logic        enq_op = 1'b0;
  logic [31:0] enq_dividend = '0;
  logic [31:0] enq_divisor = '0;
  logic        div_valid_in;
  logic        div_ready;
  logic [3:0]  div_rob;
  logic        div_op;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_valid_out;
  logic        div_yumi;
  logic [31:0] div_result;
  logic [3:0]  div_result_rob;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [3:0]  cdb_rob;
  logic [31:0] cdb_result;

  int total = 0;
  int bad = 0;
  int issue_cnt = 0;
  int cdb_cnt = 0;

  always #5 clk = ~clk;

  div_issue_ctrl #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_rob(enq_rob), .enq_op(enq_op),
    .enq_dividend(enq_dividend), .enq_divisor(enq_divisor),
    .div_valid_in(div_valid_in), .div_ready(div_ready), .div_rob(div_rob), .div_op(div_op),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_valid_out(div_valid_out), .div_yumi(div_yumi), .div_result(div_result),
    .div_result_rob(div_result_rob),
    .cdb_req(cdb_req), .cdb_grant(cdb_grant), .cdb_rob(cdb_rob), .cdb_result(cdb_result)
  );

  // ---------------- divider model: fixed latency, result held until yumi ----------------
  localparam int DIV_LAT = 4;
  logic div_ready_en = 1'b1;
  logic m_busy;
  int   m_cnt;

  assign div_ready = div_ready_en && !m_busy;

  function automatic logic [31:0] div_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic op);
    if (op) return $signed(a) / $signed(b);
    return a % b;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy         <= 1'b0;
      m_cnt          <= 0;
      div_valid_out  <= 1'b0;
      div_result     <= '0;
      div_result_rob <= '0;
    end else if (!m_busy) begin
      if (div_valid_in) begin
        m_busy <= 1'b1;
        m_cnt  <= DIV_LAT;
      end
    end else if (div_valid_out) begin
      if (div_yumi) begin
        div_valid_out <= 1'b0;
        m_busy        <= 1'b0;
      end
    end else if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else begin
      div_valid_out  <= 1'b1;
      div_result     <= div_model(div_dividend, div_divisor, div_op);
      div_result_rob <= div_rob;
    end
  end

  always @(posedge clk) begin
    if (div_valid_in) issue_cnt <= issue_cnt + 1;
    if (cdb_req)      cdb_cnt   <= cdb_cnt + 1;
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Offers one op for one cycle (cycle 0); returns sampled in cycle 1.
  task automatic enq_one(input logic [3:0] rob, input logic op,
                         input logic [31:0] a, input logic [31:0] b);
    tick();
    enq_valid = 1'b1; enq_rob = rob; enq_op = op; enq_dividend = a; enq_divisor = b;
    #1;
    tick();
    enq_valid = 1'b0;
    #1;
  endtask

  task automatic wait_cdb(input int max_cyc, output bit got);
    got = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (cdb_req === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic grant_one();
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick();
    tick();
    total++; if (enq_ready !== 1'b1) begin bad++; $display("FAIL reset_enq_ready: got %b want 1", enq_ready); end
    total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL reset_cdb_req: got %b want 0", cdb_req); end
    total++; if (div_valid_in !== 1'b0 || div_yumi !== 1'b0) begin bad++; $display("FAIL reset_div_ctl: got vin=%b yumi=%b want 0 0", div_valid_in, div_yumi); end
    total++; if (div_dividend !== 32'h0 || div_divisor !== 32'h0 || div_rob !== 4'h0 || div_op !== 1'b0) begin bad++; $display("FAIL reset_div_bus: got %h %h %h %b want zeros", div_dividend, div_divisor, div_rob, div_op); end
    total++; if (cdb_rob !== 4'h0 || cdb_result !== 32'h0) begin bad++; $display("FAIL reset_cdb_bus: got %h %h want zeros", cdb_rob, cdb_result); end
    reset = 1'b0;
    tick();
    total++; if (enq_ready !== 1'b1 || cdb_req !== 1'b0) begin bad++; $display("FAIL post_reset: got ready=%b req=%b want 1 0", enq_ready, cdb_req); end
  endtask

  task automatic test_basic_div();
    int  i0;
    bit  got;
    bit  hold_ok;
    i0 = issue_cnt;
    enq_one(4'd3, 1'b1, 32'd100, 32'd7);          // now in cycle 1
    total++; if (div_valid_in !== 1'b0) begin bad++; $display("FAIL basic_vin_c1: got %b want 0", div_valid_in); end
    tick();                                       // cycle 2
    total++; if (div_valid_in !== 1'b1) begin bad++; $display("FAIL basic_vin_c2: got %b want 1", div_valid_in); end
    total++; if (div_dividend !== 32'd100 || div_divisor !== 32'd7 || div_rob !== 4'd3 || div_op !== 1'b1) begin bad++; $display("FAIL basic_operands: got %0d %0d rob=%0d op=%b want 100 7 rob=3 op=1", div_dividend, div_divisor, div_rob, div_op); end
    got = 1'b0;
    hold_ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (cdb_req === 1'b1) begin got = 1'b1; break; end
      if (div_dividend !== 32'd100 || div_divisor !== 32'd7 || div_rob !== 4'd3 || div_op !== 1'b1) hold_ok = 1'b0;
    end
    total++; if (!got) begin bad++; $display("FAIL basic_timeout: got no cdb_req want cdb_req within 20 cycles"); end
    total++; if (!hold_ok) begin bad++; $display("FAIL basic_hold: got operands changed while busy want stable 100/7"); end
    total++; if (issue_cnt - i0 != 1) begin bad++; $display("FAIL basic_issue_count: got %0d want 1", issue_cnt - i0); end
    total++; if (cdb_rob !== 4'd3 || cdb_result !== 32'd14) begin bad++; $display("FAIL basic_result: got rob=%0d res=%0d want rob=3 res=14", cdb_rob, cdb_result); end
    $display("op rob=%0d result=%h", cdb_rob, cdb_result);
    tick();
    total++; if (cdb_req !== 1'b1 || cdb_result !== 32'd14) begin bad++; $display("FAIL basic_req_held: got req=%b res=%0d want 1 14", cdb_req, cdb_result); end
    grant_one();
    total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL basic_after_grant: got %b want 0", cdb_req); end
  endtask

  task automatic test_remu_sign();
    logic [3:0]  t_rob [2] = '{4'd4, 4'd5};
    logic        t_op  [2] = '{1'b0, 1'b1};
    logic [31:0] t_a   [2] = '{32'd100, 32'hFFFF_FFCE};   // 100, -50
    logic [31:0] t_b   [2] = '{32'd7, 32'd5};
    logic [31:0] t_exp [2] = '{32'd2, 32'hFFFF_FFF6};     // 2, -10
    bit got;
    for (int i = 0; i < 2; i++) begin
      enq_one(t_rob[i], t_op[i], t_a[i], t_b[i]);
      wait_cdb(30, got);
      total++; if (!got) begin bad++; $display("FAIL remu_sign_timeout[%0d]: got no cdb_req want cdb_req", i); end
      total++; if (cdb_rob !== t_rob[i] || cdb_result !== t_exp[i]) begin bad++; $display("FAIL remu_sign_result[%0d]: got rob=%0d res=%h want rob=%0d res=%h", i, cdb_rob, cdb_result, t_rob[i], t_exp[i]); end
      $display("op rob=%0d result=%h", cdb_rob, cdb_result);
      grant_one();
    end
  endtask

  task automatic test_specials();
    logic [3:0]  t_rob [3] = '{4'd1, 4'd2, 4'd3};
    logic        t_op  [3] = '{1'b1, 1'b0, 1'b1};
    logic [31:0] t_a   [3] = '{32'd9, 32'd9, 32'h8000_0000};
    logic [31:0] t_b   [3] = '{32'd0, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] t_exp [3] = '{32'hFFFF_FFFF, 32'd9, 32'h8000_0000};
    int i0;
    i0 = issue_cnt;
    for (int i = 0; i < 3; i++) begin
      enq_one(t_rob[i], t_op[i], t_a[i], t_b[i]);  // cycle 1
      tick();                                      // cycle 2
      total++; if (div_valid_in !== 1'b0 || cdb_req !== 1'b0) begin bad++; $display("FAIL special_c2[%0d]: got vin=%b req=%b want 0 0", i, div_valid_in, cdb_req); end
      tick();                                      // cycle 3
      total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL special_latency[%0d]: got req=%b in cycle 3 want 1", i, cdb_req); end
      total++; if (cdb_rob !== t_rob[i] || cdb_result !== t_exp[i]) begin bad++; $display("FAIL special_result[%0d]: got rob=%0d res=%h want rob=%0d res=%h", i, cdb_rob, cdb_result, t_rob[i], t_exp[i]); end
      $display("op rob=%0d result=%h", cdb_rob, cdb_result);
      grant_one();
      total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL special_after_grant[%0d]: got %b want 0", i, cdb_req); end
    end
    total++; if (issue_cnt != i0) begin bad++; $display("FAIL special_no_issue: got %0d issues want 0", issue_cnt - i0); end
  endtask

  task automatic test_backpressure();
    logic [3:0]  q_rob [5] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    logic        q_op  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] q_a   [5] = '{32'd40, 32'd9, 32'hFFFF_FFF7, 32'd1000, 32'd1};
    logic [31:0] q_b   [5] = '{32'd8, 32'd4, 32'd3, 32'd10, 32'd1};
    logic [3:0]  e_rob [5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
    logic [31:0] e_res [5] = '{32'd2, 32'd5, 32'd1, 32'hFFFF_FFFD, 32'd100};
    int i0;
    bit got;
    bit stable_ok;
    i0 = issue_cnt;
    div_ready_en = 1'b0;
    enq_one(4'd1, 1'b0, 32'd17, 32'd5);            // 17 remu 5 = 2
    tick();                                        // LOAD, stalled
    total++; if (div_valid_in !== 1'b0) begin bad++; $display("FAIL bp_stall_vin: got %b want 0", div_valid_in); end
    for (int i = 0; i < 5; i++) begin
      enq_valid = 1'b1; enq_rob = q_rob[i]; enq_op = q_op[i];
      enq_dividend = q_a[i]; enq_divisor = q_b[i];
      #1;
      total++; if (enq_ready !== (i < 4)) begin bad++; $display("FAIL bp_enq_ready[%0d]: got %b want %b", i, enq_ready, (i < 4)); end
      tick();
    end
    enq_valid = 1'b0;
    total++; if (issue_cnt != i0) begin bad++; $display("FAIL bp_no_issue_stalled: got %0d want 0", issue_cnt - i0); end
    div_ready_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      wait_cdb(40, got);
      total++; if (!got) begin bad++; $display("FAIL bp_timeout[%0d]: got no cdb_req want cdb_req", k); end
      total++; if (cdb_rob !== e_rob[k] || cdb_result !== e_res[k]) begin bad++; $display("FAIL bp_order[%0d]: got rob=%0d res=%h want rob=%0d res=%h", k, cdb_rob, cdb_result, e_rob[k], e_res[k]); end
      $display("op rob=%0d result=%h", cdb_rob, cdb_result);
      if (k == 0) begin
        stable_ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
          tick();
          if (cdb_req !== 1'b1 || cdb_rob !== e_rob[0] || cdb_result !== e_res[0]) stable_ok = 1'b0;
        end
        total++; if (!stable_ok) begin bad++; $display("FAIL bp_req_stable: got change while grant low want stable rob=1 res=2"); end
      end
      grant_one();
    end
    total++; if (issue_cnt - i0 != 5) begin bad++; $display("FAIL bp_issue_count: got %0d want 5", issue_cnt - i0); end
  endtask

  task automatic test_flush_busy();
    int i0;
    int c0;
    bit got;
    c0 = cdb_cnt;
    div_ready_en = 1'b0;
    tick();                                        // cycle 0
    enq_valid = 1'b1; enq_rob = 4'd7; enq_op = 1'b1; enq_dividend = 32'd50; enq_divisor = 32'd5;
    tick();                                        // cycle 1
    enq_rob = 4'd8; enq_op = 1'b0; enq_dividend = 32'd30; enq_divisor = 32'd4;
    tick();                                        // cycle 2
    enq_rob = 4'd10; enq_op = 1'b1; enq_dividend = 32'd60; enq_divisor = 32'd6;
    tick();                                        // cycle 3
    enq_valid = 1'b0;
    i0 = issue_cnt;
    tick();                                        // cycle 4: issue
    div_ready_en = 1'b1;
    #1;
    total++; if (div_valid_in !== 1'b1) begin bad++; $display("FAIL flush_issue: got %b want 1", div_valid_in); end
    tick();                                        // cycle 5
    tick();                                        // cycle 6: flush, with an enq that must be dropped
    flush = 1'b1;
    enq_valid = 1'b1; enq_rob = 4'd12; enq_op = 1'b0; enq_dividend = 32'd5; enq_divisor = 32'd3;
    #1;
    tick();                                        // cycle 7: DRAIN
    flush = 1'b0;
    enq_valid = 1'b0;
    #1;
    total++; if (div_dividend !== 32'd50 || div_rob !== 4'd7) begin bad++; $display("FAIL flush_drain_hold: got %0d rob=%0d want 50 rob=7", div_dividend, div_rob); end
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (div_yumi === 1'b1) begin got = 1'b1; break; end
      tick();
    end
    total++; if (!got) begin bad++; $display("FAIL flush_drain_yumi: got no yumi want yumi within 20 cycles"); end
    for (int c = 0; c < 8; c++) tick();
    total++; if (issue_cnt - i0 != 1) begin bad++; $display("FAIL flush_queue_cleared: got %0d issues want 1", issue_cnt - i0); end
    total++; if (cdb_cnt != c0) begin bad++; $display("FAIL flush_no_cdb: got %0d cdb_req cycles want 0", cdb_cnt - c0); end
    enq_one(4'd9, 1'b0, 32'd23, 32'd6);            // 23 remu 6 = 5
    wait_cdb(30, got);
    total++; if (!got || cdb_rob !== 4'd9 || cdb_result !== 32'd5) begin bad++; $display("FAIL flush_next_op: got req=%b rob=%0d res=%0d want 1 rob=9 res=5", got, cdb_rob, cdb_result); end
    $display("op rob=%0d result=%h", cdb_rob, cdb_result);
    grant_one();
  endtask

  task automatic test_flush_load_result();
    int i0;
    int c0;
    i0 = issue_cnt;
    c0 = cdb_cnt;
    enq_one(4'd10, 1'b1, 32'd60, 32'd6);           // cycle 1
    tick();                                        // cycle 2: LOAD with div_ready
    flush = 1'b1;
    #1;
    total++; if (div_valid_in !== 1'b0) begin bad++; $display("FAIL flush_load_vin: got %b want 0", div_valid_in); end
    tick();
    flush = 1'b0;
    for (int c = 0; c < 6; c++) tick();
    total++; if (issue_cnt != i0 || cdb_cnt != c0) begin bad++; $display("FAIL flush_load_dropped: got issues=%0d reqs=%0d want 0 0", issue_cnt - i0, cdb_cnt - c0); end
    enq_one(4'd11, 1'b1, 32'd9, 32'd0);            // special, cycle 1
    tick();
    tick();                                        // cycle 3: RESULT
    total++; if (cdb_req !== 1'b1) begin bad++; $display("FAIL flush_result_req: got %b want 1", cdb_req); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    total++; if (cdb_req !== 1'b0) begin bad++; $display("FAIL flush_result_drop: got %b want 0", cdb_req); end
    for (int c = 0; c < 4; c++) tick();
    total++; if (cdb_cnt - c0 != 1) begin bad++; $display("FAIL flush_result_cycles: got %0d want 1", cdb_cnt - c0); end
  endtask

  task automatic test_reset_busy();
    bit got;
    enq_one(4'd5, 1'b1, 32'd77, 32'd7);            // cycle 1
    tick();                                        // cycle 2: issue
    tick();                                        // cycle 3: BUSY
    tick();                                        // cycle 4
    total++; if (div_dividend !== 32'd77) begin bad++; $display("FAIL rst_busy_setup: got %0d want 77", div_dividend); end
    reset = 1'b1;
    #1;
    total++; if (enq_ready !== 1'b1 || cdb_req !== 1'b0 || div_valid_in !== 1'b0 || div_yumi !== 1'b0) begin bad++; $display("FAIL rst_async_ctl: got ready=%b req=%b vin=%b yumi=%b want 1 0 0 0", enq_ready, cdb_req, div_valid_in, div_yumi); end
    total++; if (div_dividend !== 32'h0 || div_divisor !== 32'h0 || div_rob !== 4'h0 || div_op !== 1'b0) begin bad++; $display("FAIL rst_async_bus: got %h %h %h %b want zeros", div_dividend, div_divisor, div_rob, div_op); end
    tick();
    reset = 1'b0;
    enq_one(4'd6, 1'b0, 32'd100, 32'd7);           // 100 remu 7 = 2
    wait_cdb(30, got);
    total++; if (!got || cdb_rob !== 4'd6 || cdb_result !== 32'd2) begin bad++; $display("FAIL rst_fresh_op: got req=%b rob=%0d res=%0d want 1 rob=6 res=2", got, cdb_rob, cdb_result); end
    $display("op rob=%0d result=%h", cdb_rob, cdb_result);
    grant_one();
  endtask

  initial begin
    test_reset();
    test_basic_div();
    test_remu_sign();
    test_specials();
    test_backpressure();
    test_flush_busy();
    test_flush_load_result();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
